// File: rtl/mult_div_unit_pkg.sv
// Multiply/divide unit shared types and op codes.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mult_div_unit_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MTHI  = 4'd5;
  localparam md_op_t MD_MTLO  = 4'd6;
  localparam md_op_t MD_MADD  = 4'd7;
  localparam md_op_t MD_MADDU = 4'd8;
  localparam md_op_t MD_MSUB  = 4'd9;
  localparam md_op_t MD_MSUBU = 4'd10;

  function automatic logic is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul(input md_op_t op);
    logic m;
    m = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
    m = m || (op == MD_MADD) || (op == MD_MADDU)
          || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return m;
  endfunction

  function automatic logic is_long(input md_op_t op);
    return is_mul(op) || is_div(op);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage HI/LO op request and result bundle.
// master drives the op, slave is the multiply/divide unit.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic        md_en;
  md_op_t      md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        mf_sel;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output md_en, md_op, A, B, mf_sel,
    input  start, busy, hi, lo, md_out
  );

  modport slave (
    input  md_en, md_op, A, B, mf_sel,
    output start, busy, hi, lo, md_out
  );

endinterface

// File: rtl/mult_div_unit_core.sv
// Combinational datapath: {op, A, B, hi, lo} -> {phi, plo, div0}.
// MDU_MADD_EN adds the accumulate ops on {hi,lo}.
module mdu_core
  import mult_div_unit_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] phi,
  output logic [31:0] plo,
  output logic        div0
);

  logic [63:0] sp;
  logic [63:0] up;
  logic [31:0] bs;
  logic        ovf;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  // low 64 bits of the sign-extended product equal the signed product
  assign sp = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign up = {32'b0, a} * {32'b0, b};

  // divisor 1 covers both B==0 and the 0x80000000/-1 overflow
  assign div0 = (b == 32'b0);
  assign ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign bs   = (div0 || ovf) ? 32'd1 : b;
  assign sq   = $signed(a) / $signed(bs);
  assign sr   = $signed(a) % $signed(bs);
  assign uq   = a / bs;
  assign ur   = a % bs;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo};
`endif

  always_comb begin
    phi = 32'b0;
    plo = 32'b0;
    unique case (1'b1)
      op == MD_MULT:  {phi, plo} = sp;
      op == MD_MULTU: {phi, plo} = up;
      op == MD_DIV:   {phi, plo} = {sr, sq};
      op == MD_DIVU:  {phi, plo} = {ur, uq};
`ifdef MDU_MADD_EN
      op == MD_MADD:  {phi, plo} = acc + sp;
      op == MD_MADDU: {phi, plo} = acc + up;
      op == MD_MSUB:  {phi, plo} = acc - sp;
      op == MD_MSUBU: {phi, plo} = acc - up;
`endif
      default: ;
    endcase
    if (is_div(op) && div0) begin
      phi = hi;
      plo = lo;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO and a fixed-latency busy window.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mult_div_unit_if.slave md
);

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  logic [3:0]  cnt, cnt_n;
  logic [31:0] hi_q, hi_n;
  logic [31:0] lo_q, lo_n;
  logic [31:0] phi, phi_n;
  logic [31:0] plo, plo_n;
  logic        pwr, pwr_n;
  logic [31:0] c_hi, c_lo;
  logic        c_div0;
  logic        idle, go, mt_hi, mt_lo;

  mdu_core u_core (
    .op   (md.md_op),
    .a    (md.A),
    .b    (md.B),
    .hi   (hi_q),
    .lo   (lo_q),
    .phi  (c_hi),
    .plo  (c_lo),
    .div0 (c_div0)
  );

  assign idle  = (cnt == 4'd0);
  assign go    = md.start & idle;
  assign mt_hi = md.md_en & idle & (md.md_op == MD_MTHI);
  assign mt_lo = md.md_en & idle & (md.md_op == MD_MTLO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= 4'd0;
      hi_q <= 32'b0;
      lo_q <= 32'b0;
      phi  <= 32'b0;
      plo  <= 32'b0;
      pwr  <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      hi_q <= hi_n;
      lo_q <= lo_n;
      phi  <= phi_n;
      plo  <= plo_n;
      pwr  <= pwr_n;
    end
  end

  always_comb begin
    cnt_n = cnt;
    hi_n  = hi_q;
    lo_n  = lo_q;
    phi_n = phi;
    plo_n = plo;
    pwr_n = pwr;
    if (!idle) begin
      cnt_n = cnt - 4'd1;
      if (cnt == 4'd1) begin
        pwr_n = 1'b0;
        if (pwr) begin
          hi_n = phi;
          lo_n = plo;
        end
      end
    end else if (go) begin
      cnt_n = is_div(md.md_op) ? DC : MC;
      phi_n = c_hi;
      plo_n = c_lo;
      pwr_n = !(is_div(md.md_op) && c_div0);
    end else if (mt_hi) begin
      hi_n = md.A;
    end else if (mt_lo) begin
      lo_n = md.A;
    end
  end

  assign md.start  = md.md_en & is_long(md.md_op);
  assign md.busy   = !idle;
  assign md.hi     = hi_q;
  assign md.lo     = lo_q;
  assign md.md_out = md.mf_sel ? hi_q : lo_q;

endmodule
